mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Round-robin scheduler that shares one iterative 32×32 → 64-bit multiplier (the `multiplier_iterative` block) among `N_REQ` requesters. It accepts one operand pair at a time and drives the multiplier's `valid_in`/`a`/`b`. It captures the 64-bit product and returns it on a single tagged response channel with ready/valid backpressure. It sits between the requesting datapath units and the single multiplier instance.

## Interface
- `N_REQ`, default 4, number of requesters (2..16).
- `TIMEOUT_CYCLES`, default 48, BUSY watchdog limit; used only with `MULT_ARB_TIMEOUT_EN`.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `req_valid` input `N_REQ`: bit k means requester k has an operand pair.
- `req_ready` output `N_REQ`: one-hot grant; a request transfers when `req_valid[k] && req_ready[k]`.
- `req_a` input `32*N_REQ`: operand a; requester k uses bits `[32k+31:32k]`.
- `req_b` input `32*N_REQ`: operand b, same packing as `req_a`.
- `resp_valid` output 1: a response is held.
- `resp_ready` input 1: the consumer accepts the response.
- `resp_id` output `$clog2(N_REQ)`: index of the requester that owns the response.
- `resp_r` output 64: product.
- `resp_err` output 1: watchdog expired; `resp_r` is 0 when set.
- `mul_valid_in` output 1: start pulse to the multiplier.
- `mul_a` output 32: operand a to the multiplier.
- `mul_b` output 32: operand b to the multiplier.
- `mul_valid_out` input 1: done flag from the multiplier; it stays high after completion until the next start.
- `mul_r` input 64: product from the multiplier.

## Operation
- The FSM has four states: IDLE, ISSUE, BUSY, RESP. Reset enters IDLE.
- **IDLE**
  - `req_ready` is the one-hot round-robin grant among the asserted `req_valid` bits, searching from `rr_ptr` upward with wrap-around.
  - On a handshake with requester k: latch `a`, `b` and `id=k`, set `rr_ptr = (k+1) mod N_REQ`, go to ISSUE.
  - With no valid request, `req_ready` is 0 and the FSM stays in IDLE.
- **ISSUE**
  - Lasts exactly one cycle.
  - `mul_valid_in=1`, with `mul_a`/`mul_b` taken from the latched operands. `mul_a`/`mul_b` hold the latched operands in every state.
  - Go to BUSY.
- **BUSY**
  - Sample `mul_valid_out`. On 1: capture `mul_r`, set `resp_err=0`, go to RESP.
  - The stale high `mul_valid_out` left from the previous job is never sampled: the multiplier clears it at the ISSUE edge.
- **RESP**
  - `resp_valid=1`; `resp_id`, `resp_r` and `resp_err` are stable while it is high.
  - On `resp_ready`: go to IDLE.
  - `req_ready` is 0 in every state except IDLE. `req_*` inputs arriving while the block is busy are held by the requesters and are not dropped.
- **Product rule:** `resp_r` is the unsigned 64-bit product `req_a*req_b`, passed through unmodified.
- **Reset values:** `req_ready=0`, `resp_valid=0`, `resp_id=0`, `resp_r=0`, `resp_err=0`, `mul_valid_in=0`, `mul_a=0`, `mul_b=0`, `rr_ptr=0`.
- **Reset mid-operation:** the FSM returns to IDLE and the in-flight product is discarded. The multiplier has no reset; the next ISSUE restarts it cleanly.

## Timing
- Cycle 0: request handshake in IDLE.
- Cycle 1: ISSUE.
- Cycle 33: `mul_valid_out` is high, 32 cycles after ISSUE.
- Cycle 34: `resp_valid` is high.
- Back-to-back: the next accept occurs no earlier than one cycle after the RESP handshake. Minimum throughput is one job per 35 cycles.
- `resp_valid` with `resp_ready` held low: RESP persists indefinitely and no new grant is issued.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester that stays asserted waits at most `N_REQ-1` jobs.

## Configuration
- Macro: `MULT_ARB_TIMEOUT_EN`.
- **Defined:**
  - A cycle counter is cleared on entering BUSY.
  - If it reaches `TIMEOUT_CYCLES` without `mul_valid_out`, the FSM goes to RESP with `resp_err=1` and `resp_r=0`.
  - The counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- **Undefined:** no counter is built, BUSY waits forever, and `resp_err` is tied to 0.

## Structure
- Package `mult_arb_pkg`:
  - `typedef enum logic[1:0] {IDLE, ISSUE, BUSY, RESP} mult_arb_state_t`
  - `localparam MUL_LATENCY = 32`
  - `localparam MUL_WIDTH = 32`
- Sub-module `rr_arbiter` (parameter N) computes the one-hot grant from `req_valid` and `rr_ptr`. It is combinational. `rr_ptr` is held in `mult_arbiter`.

## Test plan
- Single request: requester 2 sends a=7, b=6 → `resp_valid` in cycle 34 with `resp_id=2`, `resp_r=42`, `resp_err=0`.
- Full contention: all 4 `req_valid` held from reset → grants in order 0, 1, 2, 3, 0; each `resp_r` matches its own operands; no requester is starved.
- Backpressure: `resp_ready` held low for 10 cycles → `resp_valid` and `resp_r` stable, `req_ready` stays 0; the result is accepted on the cycle `resp_ready` rises.
- Width corner case: a=b=32'hFFFF_FFFF → `resp_r=64'hFFFF_FFFE_0000_0001`.
- Reset at cycle 15 of BUSY, then a new request a=3, b=5 → `resp_r=15`; no stale product appears.
- With `MULT_ARB_TIMEOUT_EN` and the multiplier stubbed with `mul_valid_out=0` → `resp_valid` rises `TIMEOUT_CYCLES`+1 cycles after entering BUSY, with `resp_err=1` and `resp_r=0`.

Source files
------------

// File: rtl/mult_arbiter_pkg.sv
// Shared types and constants for the round-robin multiplier front end.
// Used by mult_arbiter and rr_arbiter.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } mult_arb_state_t;

    localparam int MUL_LATENCY = 32;
    localparam int MUL_WIDTH   = 32;
    localparam int PROD_WIDTH  = 2 * MUL_WIDTH;

    // Successor of index k in a ring of n entries.
    function automatic int wrap_inc(input int k, input int n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// Combinational round-robin grant: lowest requester at or above rr_ptr
// (with wrap-around) wins; the grant is one-hot or all-zero.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_valid,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic [N-1:0]         grant
);

    localparam int PW = $clog2(N);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Scan offsets from far to near so the nearest valid requester overwrites the rest.
    always_comb begin
        grant = '0;
        sum   = '0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + (PW + 1)'(i);
            if (sum >= (PW + 1)'(N)) begin
                sum = sum - (PW + 1)'(N);
            end
            idx = sum[PW-1:0];
            if (req_valid[idx]) begin
                grant = N'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one iterative 32x32->64 multiplier among N_REQ requesters.
// Optional BUSY watchdog is built when MULT_ARB_TIMEOUT_EN is defined.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 48
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [MUL_WIDTH*N_REQ-1:0]   req_a,
    input  logic [MUL_WIDTH*N_REQ-1:0]   req_b,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [$clog2(N_REQ)-1:0]     resp_id,
    output logic [PROD_WIDTH-1:0]        resp_r,
    output logic                         resp_err,
    output logic                         mul_valid_in,
    output logic [MUL_WIDTH-1:0]         mul_a,
    output logic [MUL_WIDTH-1:0]         mul_b,
    input  logic                         mul_valid_out,
    input  logic [PROD_WIDTH-1:0]        mul_r
);

    localparam int IDW = $clog2(N_REQ);

    mult_arb_state_t state, state_nxt;

    logic [IDW-1:0]        rr_ptr;
    logic [N_REQ-1:0]      grant;
    logic [IDW-1:0]        grant_idx;
    logic [MUL_WIDTH-1:0]  sel_a;
    logic [MUL_WIDTH-1:0]  sel_b;
    logic                  accept;
    logic                  wd_expired;

    logic [MUL_WIDTH-1:0]  a_q;
    logic [MUL_WIDTH-1:0]  b_q;
    logic [IDW-1:0]        id_q;
    logic [PROD_WIDTH-1:0] prod_q;

    function automatic logic [IDW-1:0] onehot_idx(input logic [N_REQ-1:0] oh);
        logic [IDW-1:0] r;
        r = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (oh[k]) begin
                r = r | IDW'(k);
            end
        end
        return r;
    endfunction

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant)
    );

    assign grant_idx = onehot_idx(grant);
    assign accept    = (state == IDLE) && (|grant);

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                sel_a = req_a[k*MUL_WIDTH +: MUL_WIDTH];
                sel_b = req_b[k*MUL_WIDTH +: MUL_WIDTH];
            end
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_cnt;
    logic          err_q;

    assign wd_expired = (wd_cnt == TW'(TIMEOUT_CYCLES));

    // Held at zero outside BUSY, so it starts from zero on every BUSY entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state != BUSY) begin
            wd_cnt <= '0;
        end else if (!wd_expired) begin
            wd_cnt <= wd_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == BUSY && mul_valid_out) begin
            err_q <= 1'b0;
        end else if (state == BUSY && wd_expired) begin
            err_q <= 1'b1;
        end
    end

    assign resp_err = err_q;
`else
    assign wd_expired = 1'b0;
    assign resp_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = BUSY;
            BUSY:    if (mul_valid_out || wd_expired) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = '0;
        mul_valid_in = 1'b0;
        resp_valid   = 1'b0;
        case (state)
            IDLE:    req_ready    = grant;
            ISSUE:   mul_valid_in = 1'b1;
            RESP:    resp_valid   = 1'b1;
            default: ;
        endcase
    end

    // Operand/owner capture on accept; product capture when BUSY resolves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
            prod_q <= '0;
        end else begin
            if (accept) begin
                a_q    <= sel_a;
                b_q    <= sel_b;
                id_q   <= grant_idx;
                rr_ptr <= IDW'(wrap_inc(int'(grant_idx), N_REQ));
            end
            if (state == BUSY && mul_valid_out) begin
                prod_q <= mul_r;
            end else if (state == BUSY && wd_expired) begin
                prod_q <= '0;
            end
        end
    end

    assign mul_a   = a_q;
    assign mul_b   = b_q;
    assign resp_id = id_q;
    assign resp_r  = prod_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural iterative-multiplier model.
// Define MULT_ARB_TIMEOUT_EN on both files to add the watchdog scenario.
module tb_mult_arbiter;
    import mult_arb_pkg::*;

    localparam int N   = 4;
    localparam int T   = 48;
    localparam int IDW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [63:0]       resp_r;
    logic              resp_err;
    logic              mul_valid_in;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic              mul_valid_out;
    logic [63:0]       mul_r;

    mult_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_r        (resp_r),
        .resp_err      (resp_err),
        .mul_valid_in  (mul_valid_in),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_valid_out (mul_valid_out),
        .mul_r         (mul_r)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Iterative multiplier: done flag rises 32 cycles after the start pulse, no reset.
    bit          stub = 1'b0;
    logic        m_valid = 1'b0;
    logic [63:0] m_r = '0;
    int          m_cnt = 0;
    always @(posedge clk) begin
        if (mul_valid_in === 1'b1) begin
            m_valid <= 1'b0;
            m_cnt   <= MUL_LATENCY - 1;
            m_r     <= 64'(mul_a) * 64'(mul_b);
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !stub) m_valid <= 1'b1;
        end
    end
    assign mul_valid_out = m_valid;
    assign mul_r         = m_valid ? m_r : 64'hDEAD_BEEF_0BAD_F00D;

    typedef struct {
        int          id;
        logic [63:0] r;
        logic        err;
        longint      due;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    longint      last_pop_cyc = -1;
    longint      issue_cyc = -1;
    logic [31:0] iss_a, iss_b;
    logic [31:0] opa[N];
    logic [31:0] opb[N];
    logic [N-1:0] pend = '0;
    int          exp_ptr = 0;
    int          n_hs = 0;
    bit          refill = 1'b0;
    bit          rnd_mode = 1'b0;
    bit          bp_mode = 1'b0;
    int          bp_cnt = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_a[32*k +: 32] = opa[k];
            req_b[32*k +: 32] = opb[k];
        end
        req_valid = pend;
    endtask

    function automatic logic [31:0] rand32();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic new_req(input int k);
        pend[k] = 1'b1;
        opa[k]  = rand32();
        opb[k]  = rand32();
    endtask

    // Next owner in round-robin order among pending requesters, -1 if none.
    function automatic int model_pick();
        for (int i = 0; i < N; i++) begin
            if (pend[(exp_ptr + i) % N]) return (exp_ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic step();
        logic [N-1:0] acc;
        logic [N-1:0] eg;
        int k;
        exp_t e;
        acc = '0;
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (cyc == issue_cyc) begin
                check_eq("issue_pulse", 64'(mul_valid_in), 64'(1));
                check_eq("issue_a", 64'(mul_a), 64'(iss_a));
                check_eq("issue_b", 64'(mul_b), 64'(iss_b));
            end else begin
                check_eq("no_issue", 64'(mul_valid_in), 64'(0));
            end
            if (sb.size() == 0 && last_pop_cyc != cyc) begin
                k  = model_pick();
                eg = '0;
                if (k >= 0) eg[k] = 1'b1;
                check_eq("grant", 64'(req_ready), 64'(eg));
                if (k >= 0) begin
                    e.id  = k;
                    e.err = stub;
                    e.r   = stub ? 64'h0 : 64'(opa[k]) * 64'(opb[k]);
                    e.due = cyc + (stub ? longint'(T + 3) : 64'd34);
                    sb.push_back(e);
                    exp_ptr   = (k + 1) % N;
                    issue_cyc = cyc + 1;
                    iss_a     = opa[k];
                    iss_b     = opb[k];
                    n_hs++;
                end
            end else begin
                check_eq("ready_busy", 64'(req_ready), 64'(0));
            end
            acc = req_valid & req_ready;
        end
        @(posedge clk);
        #1;
        pend = pend & ~acc;
        if (refill) begin
            for (int j = 0; j < N; j++) if (acc[j]) new_req(j);
        end
        if (rnd_mode) begin
            for (int j = 0; j < N; j++) if (!pend[j] && $urandom_range(0, 3) == 0) new_req(j);
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        if (bp_mode) begin
            if (resp_valid) bp_cnt++;
            resp_ready = (bp_cnt >= 11);
        end
        drive();
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((sb.size() != 0 || pend != '0) && n < bound) begin
            step();
            n++;
        end
        check_eq("drain_done", 64'(sb.size() != 0 || pend != '0), 64'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        pend      = '0;
        exp_ptr   = 0;
        issue_cyc = -1;
        drive();
        step();
        check_eq("rst_req_ready", 64'(req_ready), 64'(0));
        check_eq("rst_resp_valid", 64'(resp_valid), 64'(0));
        check_eq("rst_resp_id", 64'(resp_id), 64'(0));
        check_eq("rst_resp_r", resp_r, 64'(0));
        check_eq("rst_resp_err", 64'(resp_err), 64'(0));
        check_eq("rst_mul_valid_in", 64'(mul_valid_in), 64'(0));
        check_eq("rst_mul_a", 64'(mul_a), 64'(0));
        check_eq("rst_mul_b", 64'(mul_b), 64'(0));
        step();
        rst_n = 1'b1;
    endtask

    // Response monitor: checks latency, owner, product and stability, pops on handshake.
    exp_t mon_e;
    bit   mon_seen = 1'b0;
    bit   mon_prev_pop = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_seen     = 1'b0;
            mon_prev_pop = 1'b0;
        end else begin
            if (mon_prev_pop) check_eq("resp_drop", 64'(resp_valid), 64'(0));
            mon_prev_pop = 1'b0;
            if (resp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_resp", resp_r, 64'(0));
                    check_eq("unexpected_resp_valid", 64'(resp_valid), 64'(0));
                end else begin
                    mon_e = sb[0];
                    if (!mon_seen) begin
                        check_eq("latency", 64'(cyc), 64'(mon_e.due));
                        mon_seen = 1'b1;
                    end
                    check_eq("resp_id", 64'(resp_id), 64'(mon_e.id));
                    check_eq("resp_r", resp_r, mon_e.r);
                    check_eq("resp_err", 64'(resp_err), 64'(mon_e.err));
                    if (resp_ready) begin
                        void'(sb.pop_front());
                        mon_seen     = 1'b0;
                        mon_prev_pop = 1'b1;
                        last_pop_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, %0d jobs pending", sb.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        int h0, n;
        for (int k = 0; k < N; k++) begin
            opa[k] = '0;
            opb[k] = '0;
        end
        resp_ready = 1'b1;
        drive();
        do_reset();

        // Single request from requester 2: 7*6.
        pend[2] = 1'b1; opa[2] = 32'd7; opb[2] = 32'd6;
        drive();
        drain(100);

        // Full contention from reset.
        do_reset();
        for (int k = 0; k < N; k++) new_req(k);
        drive();
        refill = 1'b1;
        h0 = n_hs; n = 0;
        while (n_hs < h0 + 5 && n < 400) begin step(); n++; end
        refill = 1'b0;
        drain(400);

        // Backpressure with another requester waiting.
        bp_mode = 1'b1; bp_cnt = 0; resp_ready = 1'b0;
        new_req(0);
        drive();
        step();
        new_req(3);
        drive();
        drain(200);
        bp_mode = 1'b0; resp_ready = 1'b1;

        // Width corner.
        pend[1] = 1'b1; opa[1] = 32'hFFFF_FFFF; opb[1] = 32'hFFFF_FFFF;
        drive();
        drain(100);

        // Reset in the middle of BUSY, then a fresh job.
        pend[0] = 1'b1; opa[0] = 32'd9; opb[0] = 32'd9;
        drive();
        h0 = n_hs; n = 0;
        while (n_hs == h0 && n < 20) begin step(); n++; end
        repeat (15) step();
        do_reset();
        pend[2] = 1'b1; opa[2] = 32'd3; opb[2] = 32'd5;
        drive();
        drain(100);

        // Randomised traffic with random backpressure.
        rnd_mode = 1'b1;
        h0 = n_hs; n = 0;
        while (n_hs < h0 + 40 && n < 5000) begin step(); n++; end
        rnd_mode = 1'b0;
        resp_ready = 1'b1;
        drain(600);

`ifdef MULT_ARB_TIMEOUT_EN
        // Multiplier never completes: watchdog answers with an error response.
        stub = 1'b1;
        pend[1] = 1'b1; opa[1] = 32'd7; opb[1] = 32'd6;
        drive();
        drain(T + 100);
        stub = 1'b0;
        pend[3] = 1'b1; opa[3] = 32'd11; opb[3] = 32'd13;
        drive();
        drain(100);
`endif

        check_eq("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
